// File: rtl/dmem_arb_pkg.sv
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared state encoding and default widths for the dual
//                M-stage data-memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

   // Arbiter FSM state encoding
   typedef logic [1:0] arb_state_t;

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_ACC1 = 2'd1;
   localparam logic [1:0] c_ACC2 = 2'd2;
   localparam logic [1:0] c_DONE = 2'd3;

   // Default widths
   localparam int c_DEF_AW      = 32;
   localparam int c_DEF_DW      = 32;
   localparam int c_DEF_TIMEOUT = 255;
   localparam int c_DEF_CNTW    = 16;

endpackage : dmem_arb_pkg

`default_nettype wire

// File: rtl/dmem_watchdog.sv
// ============================================================================
//  Module      : dmem_watchdog
//  Description : Counts cycles spent waiting for a memory acknowledge and
//                flags (sticky) an access that waits TIMEOUT cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,     // a new access is being launched
   input  logic waiting,   // in an access cycle with no acknowledge
   output logic expire,    // this waiting cycle brings the count to TIMEOUT
   output logic err        // sticky timeout flag
);

   localparam int              c_CW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [c_CW-1:0] c_LAST = c_CW'(TIMEOUT - 1);

   logic [c_CW-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;

   // Expiry fires on the waiting cycle whose increment would reach TIMEOUT
   assign expire = waiting && (cnt_q == c_LAST);
   assign err    = err_q;

   // Next-state: clear has priority so a chained access starts a fresh count
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (clear) begin
         cnt_d = '0;
      end else if (waiting) begin
         cnt_d = cnt_q + c_CW'(1);
      end
      if (expire) begin
         err_d = 1'b1;
      end
   end

   // Counter and sticky error registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

endmodule : dmem_watchdog

`default_nettype wire

// File: rtl/dual_dmem_arbiter.sv
// ============================================================================
//  Module      : dual_dmem_arbiter
//  Description : Serialises the two M-stage memory slots (older first) onto a
//                single-ported variable-latency data memory, stalling the
//                pipeline until both accesses complete.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dual_dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW      = c_DEF_AW,
   parameter int DW      = c_DEF_DW,
   parameter int TIMEOUT = c_DEF_TIMEOUT,
   parameter int CNTW    = c_DEF_CNTW
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            MemReq1M,
   input  logic            MemWrite1M,
   input  logic [AW-1:0]   Addr1M,
   input  logic [DW-1:0]   WData1M,
   input  logic            MemReq2M,
   input  logic            MemWrite2M,
   input  logic [AW-1:0]   Addr2M,
   input  logic [DW-1:0]   WData2M,
   output logic [DW-1:0]   RData1M,
   output logic [DW-1:0]   RData2M,
   output logic            MemStallM,
   output logic            mem_req,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   input  logic            mem_ack,
   input  logic [DW-1:0]   mem_rdata,
   output logic            timeout_err,
   output logic [CNTW-1:0] stall_cycles
);

   arb_state_t      state_q, state_d;
   logic            req_q, req_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   rdata1_q, rdata1_d;
   logic [DW-1:0]   rdata2_q, rdata2_d;
   logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;

   logic            w_in_acc;
   logic            w_waiting;
   logic            w_expire;
   logic            w_launch;
   logic            w_finish;
   logic [DW-1:0]   w_rdata;

   assign w_in_acc  = (state_q == c_ACC1) || (state_q == c_ACC2);
   assign w_waiting = w_in_acc && !mem_ack;
   // A watchdog expiry completes the access exactly like an ack with zero data
   assign w_finish  = mem_ack || w_expire;
   assign w_rdata   = w_expire ? '0 : mem_rdata;

   dmem_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_launch),
      .waiting (w_waiting),
      .expire  (w_expire),
      .err     (timeout_err)
   );

   // Stall whenever an access is pending or in flight; DONE lets the pipe advance
   always_comb begin
      MemStallM = ((state_q == c_IDLE) && (MemReq1M || MemReq2M)) || w_in_acc;
   end

   // FSM next-state and memory-side datapath
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      w_launch = 1'b0;
      case (state_q)
         c_IDLE: begin
            if (MemReq1M) begin
               req_d    = 1'b1;
               we_d     = MemWrite1M;
               addr_d   = Addr1M;
               wdata_d  = WData1M;
               w_launch = 1'b1;
               state_d  = c_ACC1;
            end else if (MemReq2M) begin
               req_d    = 1'b1;
               we_d     = MemWrite2M;
               addr_d   = Addr2M;
               wdata_d  = WData2M;
               w_launch = 1'b1;
               state_d  = c_ACC2;
            end
         end
         c_ACC1: begin
            if (w_finish) begin
               if (!we_q) begin
                  rdata1_d = w_rdata;
               end
               // Slot 2 inputs are frozen by the stall, so they are valid here
               if (MemReq2M) begin
                  we_d     = MemWrite2M;
                  addr_d   = Addr2M;
                  wdata_d  = WData2M;
                  w_launch = 1'b1;
                  state_d  = c_ACC2;
               end else begin
                  req_d   = 1'b0;
                  state_d = c_DONE;
               end
            end
         end
         c_ACC2: begin
            if (w_finish) begin
               if (!we_q) begin
                  rdata2_d = w_rdata;
               end
               req_d   = 1'b0;
               state_d = c_DONE;
            end
         end
         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   // Saturating count of stalled cycles
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (MemStallM && (stall_cnt_q != {CNTW{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNTW'(1);
      end
   end

   // State, memory interface and load-result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= c_IDLE;
         req_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata1_q    <= '0;
         rdata2_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata1_q    <= rdata1_d;
         rdata2_q    <= rdata2_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_req      = req_q;
   assign mem_we       = we_q;
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign RData1M      = rdata1_q;
   assign RData2M      = rdata2_q;
   assign stall_cycles = stall_cnt_q;

endmodule : dual_dmem_arbiter

`default_nettype wire

// File: tb/tb_dual_dmem_arbiter.sv
// ============================================================================
//  Module      : tb_dual_dmem_arbiter
//  Description : Directed, table-driven bench for dual_dmem_arbiter with a
//                small behavioural memory that acks after a set wait count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dual_dmem_arbiter;

   localparam int c_AW      = 32;
   localparam int c_DW      = 32;
   localparam int c_TIMEOUT = 4;
   localparam int c_CNTW    = 6;
   localparam int c_SATMAX  = 63;
   localparam int c_NEVER   = 1000;

   logic            clk;
   logic            rst_n;
   logic            MemReq1M, MemWrite1M, MemReq2M, MemWrite2M;
   logic [c_AW-1:0] Addr1M, Addr2M;
   logic [c_DW-1:0] WData1M, WData2M;
   logic [c_DW-1:0] RData1M, RData2M;
   logic            MemStallM;
   logic            mem_req, mem_we, mem_ack;
   logic [c_AW-1:0] mem_addr;
   logic [c_DW-1:0] mem_wdata, mem_rdata;
   logic            timeout_err;
   logic [c_CNTW-1:0] stall_cycles;

   dual_dmem_arbiter #(
      .AW (c_AW), .DW (c_DW), .TIMEOUT (c_TIMEOUT), .CNTW (c_CNTW)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .MemReq1M (MemReq1M), .MemWrite1M (MemWrite1M), .Addr1M (Addr1M), .WData1M (WData1M),
      .MemReq2M (MemReq2M), .MemWrite2M (MemWrite2M), .Addr2M (Addr2M), .WData2M (WData2M),
      .RData1M (RData1M), .RData2M (RData2M), .MemStallM (MemStallM),
      .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
      .mem_ack (mem_ack), .mem_rdata (mem_rdata),
      .timeout_err (timeout_err), .stall_cycles (stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        r1, w1;
      logic [31:0] a1, d1;
      logic        r2, w2;
      logic [31:0] a2, d2;
      int          waits;
      int          exp_stall;
      logic [31:0] exp_rd1, exp_rd2;
      int          exp_nacc;
      logic        exp_we0;
      logic [31:0] exp_addr0;
      logic        exp_err;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int exp_sc   = 0;

   // behavioural memory state
   logic [31:0] mem [0:255];
   logic        model_en;
   int          waits_cfg;
   int          wcnt;
   int          acc_n;
   logic        acc_we0;
   logic [31:0] acc_addr0;

   function automatic vec_t mk(logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                               logic r2, logic w2, logic [31:0] a2, logic [31:0] d2,
                               int waits, int st, logic [31:0] e1, logic [31:0] e2,
                               int nacc, logic we0, logic [31:0] ad0, logic er);
      vec_t v;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.r2 = r2; v.w2 = w2; v.a2 = a2; v.d2 = d2;
      v.waits = waits; v.exp_stall = st; v.exp_rd1 = e1; v.exp_rd2 = e2;
      v.exp_nacc = nacc; v.exp_we0 = we0; v.exp_addr0 = ad0; v.exp_err = er;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // Memory responder: acks after waits_cfg request cycles without ack
   task automatic model_update();
      if (!model_en) return;
      if (mem_req) begin
         if (wcnt == waits_cfg) begin
            mem_ack = 1'b1;
            if (mem_we) begin
               mem_rdata = 32'hBAD0_BAD0;
               mem[mem_addr[9:2]] = mem_wdata;
            end else begin
               mem_rdata = mem[mem_addr[9:2]];
            end
            if (acc_n == 0) begin
               acc_we0   = mem_we;
               acc_addr0 = mem_addr;
            end
            acc_n++;
            wcnt = 0;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hA5A5_A5A5;
            wcnt++;
         end
      end else begin
         mem_ack   = 1'b0;
         mem_rdata = 32'hA5A5_A5A5;
         wcnt      = 0;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_update();
   endtask

   task automatic do_txn(input vec_t v, input string nm);
      int n;
      acc_n = 0; acc_we0 = 1'b0; acc_addr0 = '0; wcnt = 0;
      waits_cfg = v.waits;
      MemReq1M = v.r1; MemWrite1M = v.w1; Addr1M = v.a1; WData1M = v.d1;
      MemReq2M = v.r2; MemWrite2M = v.w2; Addr2M = v.a2; WData2M = v.d2;
      #1;
      n = 0;
      while (MemStallM && n < 40) begin
         n++;
         step();
      end
      if (n >= 40) begin
         failures++;
         $display("FAIL %s_bound: stall did not drop within 40 cycles", nm);
      end
      exp_sc = exp_sc + v.exp_stall;
      if (exp_sc > c_SATMAX) exp_sc = c_SATMAX;
      chk({nm, "_stall"},   32'(n),            32'(v.exp_stall));
      chk({nm, "_rd1"},     RData1M,           v.exp_rd1);
      chk({nm, "_rd2"},     RData2M,           v.exp_rd2);
      chk({nm, "_req_off"}, 32'(mem_req),      32'd0);
      chk({nm, "_nacc"},    32'(acc_n),        32'(v.exp_nacc));
      if (v.exp_nacc > 0) begin
         chk({nm, "_we0"},   32'(acc_we0),     32'(v.exp_we0));
         chk({nm, "_addr0"}, acc_addr0,        v.exp_addr0);
      end
      chk({nm, "_err"},     32'(timeout_err),  32'(v.exp_err));
      chk({nm, "_scnt"},    32'(stall_cycles), 32'(exp_sc));
      MemReq1M = 1'b0; MemReq2M = 1'b0;
      step();
   endtask

   vec_t tbl [8];
   vec_t tov;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[8'h10] = 32'hDEAD_BEEF;            // address 0x40
      model_en = 1'b1; waits_cfg = 0; wcnt = 0; acc_n = 0;
      acc_we0 = 1'b0; acc_addr0 = '0;
      MemReq1M = 0; MemWrite1M = 0; Addr1M = '0; WData1M = '0;
      MemReq2M = 0; MemWrite2M = 0; Addr2M = '0; WData2M = '0;
      mem_ack = 0; mem_rdata = '0;
      rst_n = 1'b0;

      //                r1 w1 a1      d1        r2 w2 a2      d2        wt  st rd1           rd2           n we0 addr0  err
      tbl[0] = mk(1, 0, 32'h40, 32'h0,    0, 0, 32'h0,  32'h0,    0, 2, 32'hDEADBEEF, 32'h0,        1, 0, 32'h40, 0);
      tbl[1] = mk(1, 1, 32'h80, 32'h1234, 1, 0, 32'h80, 32'h0,    3, 9, 32'hDEADBEEF, 32'h1234,     2, 1, 32'h80, 0);
      tbl[2] = mk(0, 0, 32'h0,  32'h0,    1, 1, 32'h10, 32'h55,   0, 2, 32'hDEADBEEF, 32'h1234,     1, 1, 32'h10, 0);
      tbl[3] = mk(1, 0, 32'h80, 32'h0,    1, 0, 32'h40, 32'h0,    1, 5, 32'h1234,     32'hDEADBEEF, 2, 0, 32'h80, 0);
      tbl[4] = mk(1, 1, 32'h20, 32'hAAAA, 1, 1, 32'h20, 32'hBBBB, 0, 3, 32'h1234,     32'hDEADBEEF, 2, 1, 32'h20, 0);
      tbl[5] = mk(1, 0, 32'h20, 32'h0,    0, 0, 32'h0,  32'h0,    0, 2, 32'hBBBB,     32'hDEADBEEF, 1, 0, 32'h20, 0);
      tbl[6] = mk(0, 0, 32'h0,  32'h0,    0, 0, 32'h0,  32'h0,    0, 0, 32'hBBBB,     32'hDEADBEEF, 0, 0, 32'h0,  0);
      tbl[7] = mk(0, 0, 32'h0,  32'h0,    1, 0, 32'h10, 32'h0,    2, 4, 32'hBBBB,     32'h55,       1, 0, 32'h10, 0);
      tov    = mk(1, 0, 32'h40, 32'h0,    0, 0, 32'h0,  32'h0,    c_NEVER, 5, 32'h0,  32'h55,       0, 0, 32'h0,  1);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req",   32'(mem_req),      32'd0);
      chk("rst_we",    32'(mem_we),       32'd0);
      chk("rst_addr",  mem_addr,          32'd0);
      chk("rst_wdata", mem_wdata,         32'd0);
      chk("rst_rd1",   RData1M,           32'd0);
      chk("rst_rd2",   RData2M,           32'd0);
      chk("rst_stall", 32'(MemStallM),    32'd0);
      chk("rst_err",   32'(timeout_err),  32'd0);
      chk("rst_scnt",  32'(stall_cycles), 32'd0);
      #3 rst_n = 1'b1;
      step();

      // idle: no requests for 10 cycles
      for (int i = 0; i < 10; i++) begin
         chk("idle_stall", 32'(MemStallM), 32'd0);
         chk("idle_req",   32'(mem_req),   32'd0);
         step();
      end
      chk("idle_scnt", 32'(stall_cycles), 32'd0);

      // table-driven transactions
      for (int i = 0; i < 8; i++) begin
         do_txn(tbl[i], $sformatf("vec%0d", i));
      end

      // watchdog: no ack ever, slot 1 load abandoned with zero data
      chk("to_err_before", 32'(timeout_err), 32'd0);
      do_txn(tov, "timeout");

      // keep timing out until the stall counter must saturate at all-ones
      for (int i = 0; i < 7; i++) begin
         do_txn(tov, $sformatf("sat%0d", i));
      end
      chk("sat_final", 32'(stall_cycles), 32'(c_SATMAX));

      // reset asserted asynchronously while waiting in ACC2
      tov = mk(0, 0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0, c_NEVER, 0, 0, 0, 0, 0, 0, 0);
      waits_cfg = c_NEVER; wcnt = 0;
      MemReq2M = 1'b1; MemWrite2M = 1'b0; Addr2M = 32'h40;
      step();
      step();
      chk("mid_req_before", 32'(mem_req), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      chk("mid_req",  32'(mem_req),      32'd0);
      chk("mid_addr", mem_addr,          32'd0);
      chk("mid_rd1",  RData1M,           32'd0);
      chk("mid_rd2",  RData2M,           32'd0);
      chk("mid_err",  32'(timeout_err),  32'd0);
      chk("mid_scnt", 32'(stall_cycles), 32'd0);
      MemReq2M = 1'b0;
      #1;
      chk("mid_idle_stall", 32'(MemStallM), 32'd0);
      model_en = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      chk("stale_req",   32'(mem_req),      32'd0);
      chk("stale_stall", 32'(MemStallM),    32'd0);
      chk("stale_rd1",   RData1M,           32'd0);
      chk("stale_rd2",   RData2M,           32'd0);
      chk("stale_scnt",  32'(stall_cycles), 32'd0);
      @(posedge clk);
      #1;
      chk("stale_req2",  32'(mem_req),      32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_dual_dmem_arbiter

`default_nettype wire

// File: doc/dual_dmem_arbiter.md
Name: dual_dmem_arbiter

Overview:
Sequences the two Memory-stage pipes (slot 1 = older, slot 2 = younger) onto the single-ported, variable-latency data memory.
- Serialises accesses in program order: slot 1 first, then slot 2.
- Holds the whole pipeline stalled until both accesses complete.
- Returns load data to each pipe.
- Sits between the M-stage registers and the data memory; its stall output is ORed into the hazard unit's stall/flush equations.

Parameters:
AW, 32, address width
DW, 32, data width
TIMEOUT, 255, max cycles waiting for mem_ack before error
CNTW, 16, width of stall-cycle performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
MemReq1M  in  1  slot 1 has a qualified (non-flushed) lw/sw in M
MemWrite1M  in  1  slot 1 op is store
Addr1M  in  AW  slot 1 byte address
WData1M  in  DW  slot 1 store data
MemReq2M  in  1  slot 2 has a qualified lw/sw in M
MemWrite2M  in  1  slot 2 op is store
Addr2M  in  AW  slot 2 byte address
WData2M  in  DW  slot 2 store data
RData1M  out  DW  slot 1 load result, registered
RData2M  out  DW  slot 2 load result, registered
MemStallM  out  1  freeze F..M stages this cycle
mem_req  out  1  request to data memory, registered
mem_we  out  1  write enable, registered
mem_addr  out  AW  address, registered
mem_wdata  out  DW  write data, registered
mem_ack  in  1  one-cycle completion pulse; mem_rdata valid same cycle
mem_rdata  in  DW  read data
timeout_err  out  1  sticky: an access exceeded TIMEOUT cycles
stall_cycles  out  CNTW  saturating count of cycles with MemStallM=1

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_req/mem_we=0; mem_addr/mem_wdata/RData1M/RData2M=0; timeout_err=0; stall_cycles=0; wait counter=0. Reset mid-access abandons the access; a late mem_ack after reset is ignored in IDLE.
- States: IDLE, ACC1, ACC2, DONE.
- IDLE:
  - MemReq1M=1 -> load mem_* from slot 1 and assert mem_req; go ACC1.
  - Else MemReq2M=1 -> load from slot 2; go ACC2.
  - Else stay IDLE.
- ACC1: mem_req held and mem_* stable until mem_ack.
  - On ack: RData1M<=mem_rdata if slot 1 is a load, otherwise unchanged.
  - Then, if MemReq2M=1: reload mem_* from slot 2, keep mem_req=1, go ACC2. Else: mem_req<=0, go DONE.
- ACC2: on ack, RData2M<=mem_rdata if slot 2 is a load; mem_req<=0; go DONE.
- DONE: one cycle; MemStallM=0 so the pipeline advances and the M instructions leave; next state IDLE. Requests seen during DONE are not serviced; they belong to instructions leaving this cycle.
- MemStallM is combinational: (IDLE && (MemReq1M||MemReq2M)) || ACC1 || ACC2.
- M-stage inputs are frozen during stall, so slot 2 inputs are valid when first sampled in ACC1.
- Latency, with mem_ack one cycle after mem_req:
  - Single access: 2 stall cycles (IDLE, ACC1).
  - Dual access: 3 stall cycles.
  - No request: 0 stall cycles.
- Ordering: slot 1 store followed by slot 2 load to the same address is naturally correct. A same-address store/store pair leaves slot 2 data in memory.
- mem_ack in IDLE or DONE is ignored.
- Watchdog: the wait counter clears on entering ACC1/ACC2 and increments each cycle mem_ack=0 while in ACC1/ACC2. When it reaches TIMEOUT:
  - timeout_err<=1 (sticky until reset);
  - the access is abandoned as if acked with rdata=0;
  - the FSM proceeds normally.
- stall_cycles: +1 each cycle MemStallM=1; saturates at all-ones and never wraps.

Decomposition:
- Shared package dmem_arb_pkg: state encoding (IDLE=2'd0, ACC1=2'd1, ACC2=2'd2, DONE=2'd3) and default width constants.
- One sub-module, dmem_watchdog: wait counter plus sticky timeout_err. Inputs: clk, rst_n, clear, waiting. Outputs: expire, err.
- FSM and datapath registers stay in dual_dmem_arbiter.

Test Plan:
- Idle: MemReq1M=MemReq2M=0 for 10 cycles -> MemStallM=0, mem_req=0, stall_cycles=0.
- Single load: slot 1 lw addr 0x40, memory acks 1 cycle later with 0xDEADBEEF -> MemStallM high 2 cycles, RData1M=0xDEADBEEF in DONE, mem_req low after ack.
- Dual op: slot 1 sw 0x80 data 0x1234, slot 2 lw 0x80, ack latency 3 -> store issued first, then load; RData2M=0x1234; MemStallM high for exactly 9 cycles (IDLE + 4 ACC1 + 4 ACC2); stall_cycles=9.
- Slot 2 only: MemReq2M=1 sw 0x10 -> IDLE goes directly to ACC2, mem_addr=0x10, mem_we=1, 2 stall cycles.
- Timeout: TIMEOUT=4, no mem_ack -> after 4 wait cycles timeout_err=1, RData1M=0, FSM reaches DONE, MemStallM drops.
- Reset mid-ACC2: rst_n=0 asynchronously -> mem_req=0, state IDLE, RData*=0 immediately; a stale mem_ack after release causes no change.
